// File: rtl/datapath_pkg.sv
// Shared opcode encoding and default sizing for the pipelined register-bank datapath.
package datapath_pkg;

  localparam int XLEN_DEF = 32;
  localparam int NREG_DEF = 32;

  typedef enum logic [2:0] {
    ALU_ADD = 3'd0,
    ALU_SUB = 3'd1,
    ALU_AND = 3'd2,
    ALU_OR  = 3'd3,
    ALU_XOR = 3'd4,
    ALU_SLL = 3'd5,
    ALU_SRL = 3'd6,
    ALU_SLT = 3'd7
  } alu_op_t;

endpackage

// File: rtl/datapath_pipe_reg_bank.sv
// NREG x XLEN register bank: two operand read ports plus a debug port, one write port.
// Register 0 is never written and always reads back as zero.
module reg_bank
  import datapath_pkg::*;
#(
  parameter int XLEN = XLEN_DEF,
  parameter int NREG = NREG_DEF,
  parameter int AW   = $clog2(NREG)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            we,
  input  logic [AW-1:0]   waddr,
  input  logic [XLEN-1:0] wdata,
  input  logic [AW-1:0]   raddr_1,
  input  logic [AW-1:0]   raddr_2,
  input  logic [AW-1:0]   dbg_addr,
  output logic [XLEN-1:0] rdata_1,
  output logic [XLEN-1:0] rdata_2,
  output logic [XLEN-1:0] dbg_data
);

  logic [XLEN-1:0] r_mem [NREG];
  logic [AW-1:0]   w_raddr [3];
  logic [XLEN-1:0] w_rdata [3];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) r_mem[i] <= '0;
    end else if (we && (waddr != '0)) begin
      r_mem[waddr] <= wdata;
    end
  end

  assign w_raddr[0] = raddr_1;
  assign w_raddr[1] = raddr_2;
  assign w_raddr[2] = dbg_addr;

  generate
    for (genvar gi = 0; gi < 3; gi++) begin : g_rd
      assign w_rdata[gi] = (w_raddr[gi] == '0) ? '0 : r_mem[w_raddr[gi]];
    end
  endgenerate

  assign rdata_1  = w_rdata[0];
  assign rdata_2  = w_rdata[1];
  assign dbg_data = w_rdata[2];

endmodule

// File: rtl/datapath_pipe.sv
// Register bank + ALU with a single registered write-back stage, valid/ready handshakes
// and a WB->operand bypass so dependent ops can issue back to back.
module datapath_pipe
  import datapath_pkg::*;
#(
  parameter int   XLEN = XLEN_DEF,
  parameter int   NREG = NREG_DEF,
  localparam int  AW   = $clog2(NREG)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [2:0]      alu_control,
  input  logic [AW-1:0]   rs_1,
  input  logic [AW-1:0]   rs_2,
  input  logic [AW-1:0]   rd_0,
  input  logic            write_rb,
  input  logic            use_imm,
  input  logic [XLEN-1:0] imm,
  output logic [XLEN-1:0] alu_result,
  output logic            out_valid,
  input  logic            out_ready,
  input  logic [AW-1:0]   dbg_addr,
  output logic [XLEN-1:0] dbg_data
);

  localparam int SHW = $clog2(XLEN);

  logic [XLEN-1:0] r_result;
  logic [AW-1:0]   r_rd;
  logic            r_we;
  logic            r_out_valid;

  logic [XLEN-1:0] w_rdata_1, w_rdata_2;
  logic [XLEN-1:0] w_op_a, w_op_b, w_alu;
  logic            w_accept, w_commit, w_fwd_live;

  assign in_ready   = !r_out_valid || out_ready;
  assign w_accept   = in_valid && in_ready;
  // The pending result is architecturally "newer" than the bank until it commits.
  assign w_fwd_live = r_out_valid && r_we && (r_rd != '0);
  assign w_commit   = w_fwd_live && out_ready;

  reg_bank #(.XLEN(XLEN), .NREG(NREG), .AW(AW)) u_bank (
    .clk      (clk),
    .rst_n    (rst_n),
    .we       (w_commit),
    .waddr    (r_rd),
    .wdata    (r_result),
    .raddr_1  (rs_1),
    .raddr_2  (rs_2),
    .dbg_addr (dbg_addr),
    .rdata_1  (w_rdata_1),
    .rdata_2  (w_rdata_2),
    .dbg_data (dbg_data)
  );

  always_comb begin
    w_op_a = (w_fwd_live && (r_rd == rs_1)) ? r_result : w_rdata_1;
    w_op_b = (w_fwd_live && (r_rd == rs_2)) ? r_result : w_rdata_2;
    if (use_imm) w_op_b = imm;
  end

  always_comb begin
    w_alu = '0;
    case (alu_op_t'(alu_control))
      ALU_ADD: w_alu = w_op_a + w_op_b;
      ALU_SUB: w_alu = w_op_a - w_op_b;
      ALU_AND: w_alu = w_op_a & w_op_b;
      ALU_OR:  w_alu = w_op_a | w_op_b;
      ALU_XOR: w_alu = w_op_a ^ w_op_b;
      ALU_SLL: w_alu = w_op_a << w_op_b[SHW-1:0];
      ALU_SRL: w_alu = w_op_a >> w_op_b[SHW-1:0];
      ALU_SLT: w_alu = {{(XLEN-1){1'b0}}, ($signed(w_op_a) < $signed(w_op_b))};
      default: w_alu = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_result    <= '0;
      r_rd        <= '0;
      r_we        <= 1'b0;
      r_out_valid <= 1'b0;
    end else if (w_accept) begin
      r_result    <= w_alu;
      r_rd        <= rd_0;
      r_we        <= write_rb;
      r_out_valid <= 1'b1;
    end else if (out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  assign alu_result = r_result;
  assign out_valid  = r_out_valid;

endmodule
